// File: rtl/latency_measure.sv
// Cycle-accurate latency meter: counts clocks from a rising edge on d to the next rising edge on q.
// Emits one-cycle pulses for a result, a timeout, or a second d edge during a measurement.
module latency_measure #(
  parameter int unsigned LSIZE = 10,
  parameter int unsigned TMO   = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             d,
  input  logic             q,
  output logic [LSIZE-1:0] lat,
  output logic             lat_vld,
  output logic             timeout,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic {StIdle, StMeas} state_e;

  localparam logic [LSIZE-1:0] TmoVal = LSIZE'(TMO);

  state_e           state_q, state_d;
  logic [LSIZE-1:0] cnt_q, cnt_d;
  logic [LSIZE-1:0] lat_q, lat_d;
  logic             vld_q, vld_d;
  logic             tmo_q, tmo_d;
  logic             ovr_q, ovr_d;
  logic             d_r_q, q_r_q;
  logic             d_rise, q_rise;

  // Inputs are synchronous to clk, so edges come straight off the current inputs.
  assign d_rise = d & ~d_r_q;
  assign q_rise = q & ~q_r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lat_q   <= '0;
      vld_q   <= 1'b0;
      tmo_q   <= 1'b0;
      ovr_q   <= 1'b0;
      d_r_q   <= 1'b0;
      q_r_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      vld_q   <= vld_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
      d_r_q   <= d;
      q_r_q   <= q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    vld_d   = 1'b0;
    tmo_d   = 1'b0;
    ovr_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && d_rise) begin
          if (q_rise) begin
            lat_d = '0;
            vld_d = 1'b1;
          end else begin
            cnt_d   = LSIZE'(1);
            state_d = StMeas;
          end
        end
      end
      StMeas: begin
        if (!enable) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          // A second d edge only flags; the count keeps running from the first edge.
          ovr_d = d_rise;
          if (q_rise) begin
            lat_d   = cnt_q;
            vld_d   = 1'b1;
            state_d = StIdle;
          end else if (cnt_q == TmoVal) begin
            tmo_d   = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + LSIZE'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy    = (state_q == StMeas);
    lat     = lat_q;
    lat_vld = vld_q;
    timeout = tmo_q;
    overrun = ovr_q;
  end

endmodule

// File: doc/latency_measure.md
Name: latency_measure

Overview:
- Measures, in clock cycles, the delay between a rising edge on a stimulus input `d` and the next rising edge on an echo input `q`.
- Complementary end of the programmable-delay path: it recovers the latency value that a dynamic delay element applied.
- Used for loop-back self-check and calibration of delay chains.
- Reports each result with a one-cycle valid pulse; flags timeouts and overlapping stimuli.

Parameters:
- LSIZE, 10, width of the measured latency and internal counter.
- TMO, 1023, maximum count before timeout; legal range 1 .. 2**LSIZE-1.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  measurement enable; low aborts any measurement and holds IDLE.
- d  input  1  stimulus; a rising edge starts a measurement.
- q  input  1  echo; a rising edge ends the measurement.
- lat  output  LSIZE  last measured latency in cycles; held until next result.
- lat_vld  output  1  one-cycle pulse, coincident with the cycle `lat` updates.
- timeout  output  1  one-cycle pulse when no echo arrives within TMO cycles.
- overrun  output  1  one-cycle pulse when `d` rises again while measuring.
- busy  output  1  high while in MEAS.

Behaviour:
- Edge detection:
  - d_r and q_r are registered copies of `d` and `q`; reset value 0.
  - d_rise = d & ~d_r and q_rise = q & ~q_r, both combinational on the current inputs.
  - No input synchronisers: `d` and `q` are synchronous to clk.
- Reset (async, rst_n low): state=IDLE, cnt=0, lat=0, lat_vld=0, timeout=0, overrun=0, busy=0, d_r=q_r=0.
- `lat_vld`, `timeout` and `overrun` are registered and default to 0 every cycle unless set below.
- State IDLE:
  - enable=1 and d_rise and q_rise in the same cycle: lat<=0, lat_vld<=1, stay IDLE.
  - enable=1 and d_rise only: cnt<=1, state<=MEAS, busy<=1.
  - Otherwise hold.
- State MEAS, evaluated in priority order:
  - enable=0: state<=IDLE, busy<=0, cnt<=0; no result, no pulse.
  - q_rise: lat<=cnt, lat_vld<=1, state<=IDLE, busy<=0.
  - cnt==TMO: timeout<=1, state<=IDLE, busy<=0; `lat` unchanged.
  - Otherwise: cnt<=cnt+1.
  - Independently, d_rise in MEAS (except the enable=0 cycle): overrun<=1. It does not restart the count; the measurement continues from the first edge.
- Latency definition: if `d` rises in the cycle sampled at edge 0 and `q` rises in the cycle sampled at edge L, then lat=L.
  - A pure L-cycle delay of `d` gives lat=L, including L=0.
- Width rules:
  - cnt is LSIZE bits and never wraps, because TMO ≤ 2**LSIZE-1 bounds it.
  - `lat` is a plain copy of cnt.
- After a result or timeout the block returns to IDLE. It can start a new measurement on a d_rise that occurs one cycle after the exit cycle or later.
  - A d_rise in the same cycle as the exiting q_rise or timeout is ignored; it is in MEAS and flags overrun.
- q_rise while in IDLE without d_rise is ignored.
- Asserting rst_n low mid-measurement clears everything immediately; no pulse is emitted.

Test Plan:
- Reset: rst_n=0 with d and q toggling → all outputs 0; after release, busy=0 and lat=0.
- Loop-back q = d delayed 5 cycles, single rising edge on `d` → lat_vld one cycle, lat=5, busy high for exactly 5 cycles.
- Same-cycle rise, q=d (L=0) → lat=0 with lat_vld=1, busy never asserted. Repeat with L=1 → lat=1.
- Timeout with TMO=20: `d` rises, `q` held 0 → timeout pulses one cycle, 21 cycles after the d_rise cycle; lat keeps its previous value; busy=0 afterwards.
- Overrun: `d` pulses at cycles 0 and 3, `q` rises at cycle 8 → overrun pulse follows cycle 3, lat=8, single lat_vld.
- Abort: enable drops at cycle 4 of a measurement, `q` rises at cycle 6 → no lat_vld, no timeout, busy=0 after cycle 4. Next d→q pair with L=7 → lat=7.
